// File: rtl/hazard_flush_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch squash and memory freeze,
// with saturating stall/flush performance counters. Outputs are combinational from state and inputs.
module hazard_flush_ctrl #(
  parameter int LU_STALL_CYCLES = 1,
  parameter int BRANCH_PENALTY  = 1,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IDEX_MemRead,
  input  logic [3:0]       IDEX_RT,
  input  logic [3:0]       IFID_RS,
  input  logic [3:0]       IFID_RT,
  input  logic             IFID_uses_RT,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             PC_WRITE,
  output logic             IFID_WRITE,
  output logic             IFID_FLUSH,
  output logic             IDEX_FLUSH,
  output logic             PIPE_HOLD,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    BR_FLUSH = 2'd2
  } state_t;

  localparam logic [3:0]       LU_RELOAD = 4'(LU_STALL_CYCLES - 1);
  localparam logic [3:0]       BR_RELOAD = 4'(BRANCH_PENALTY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       lu;
  logic       flush_evt;

  assign lu = IDEX_MemRead &
              ((IDEX_RT == IFID_RS) | (IFID_uses_RT & (IDEX_RT == IFID_RT)));
  assign state_dbg = state;

  always_comb begin
    PC_WRITE   = 1'b1;
    IFID_WRITE = 1'b1;
    IFID_FLUSH = 1'b0;
    IDEX_FLUSH = 1'b0;
    PIPE_HOLD  = 1'b0;
    state_nxt  = state;
    cnt_nxt    = cnt;
    flush_evt  = 1'b0;
    if (rst) begin
      PC_WRITE   = 1'b0;
      IFID_WRITE = 1'b0;
      IFID_FLUSH = 1'b1;
      IDEX_FLUSH = 1'b1;
      state_nxt  = RUN;
      cnt_nxt    = 4'd0;
    end else if (mem_busy) begin
      // Freeze everything; pending branch/hazard is re-evaluated once memory is ready.
      PC_WRITE   = 1'b0;
      IFID_WRITE = 1'b0;
      PIPE_HOLD  = 1'b1;
    end else if (branch_taken) begin
      IFID_FLUSH = 1'b1;
      IDEX_FLUSH = 1'b1;
      flush_evt  = 1'b1;
      if (BRANCH_PENALTY > 1) begin
        state_nxt = BR_FLUSH;
        cnt_nxt   = BR_RELOAD;
      end else begin
        state_nxt = RUN;
        cnt_nxt   = 4'd0;
      end
    end else if (state == LU_STALL) begin
      PC_WRITE   = 1'b0;
      IFID_WRITE = 1'b0;
      IDEX_FLUSH = 1'b1;
      if (cnt <= 4'd1) begin
        state_nxt = RUN;
        cnt_nxt   = 4'd0;
      end else begin
        cnt_nxt = cnt - 4'd1;
      end
    end else if (lu) begin
      PC_WRITE   = 1'b0;
      IFID_WRITE = 1'b0;
      IDEX_FLUSH = 1'b1;
      if (LU_STALL_CYCLES > 1) begin
        state_nxt = LU_STALL;
        cnt_nxt   = LU_RELOAD;
      end else begin
        state_nxt = RUN;
        cnt_nxt   = 4'd0;
      end
    end else if (state == BR_FLUSH) begin
      IFID_FLUSH = 1'b1;
      if (cnt <= 4'd1) begin
        state_nxt = RUN;
        cnt_nxt   = 4'd0;
      end else begin
        cnt_nxt = cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= 4'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (!PC_WRITE && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + CNT_ONE;
      if (flush_evt && (flush_cnt != CNT_MAX))
        flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Directed bench for hazard_flush_ctrl: instance a (LU=1, BP=3, CNT_W=4) and
// instance b (LU=3, BP=1, CNT_W=16) share the same stimulus.
module tb_hazard_flush_ctrl;

  localparam logic [4:0] RUN_O   = 5'b11000; // {PC_WRITE,IFID_WRITE,IFID_FLUSH,IDEX_FLUSH,PIPE_HOLD}
  localparam logic [4:0] STALL_O = 5'b00010;
  localparam logic [4:0] BR_O    = 5'b11110;
  localparam logic [4:0] BRF_O   = 5'b11100;
  localparam logic [4:0] HOLD_O  = 5'b00001;
  localparam logic [4:0] RST_O   = 5'b00110;
  localparam logic [1:0] S_RUN = 2'd0, S_LU = 2'd1, S_BR = 2'd2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_read = 1'b0, uses_rt = 1'b0, br = 1'b0, busy = 1'b0;
  logic [3:0] idex_rt = '0, ifid_rs = '0, ifid_rt = '0;

  logic a_pc, a_ifw, a_iff, a_idf, a_hold;
  logic [3:0] a_stall, a_flush;
  logic [1:0] a_state;
  logic b_pc, b_ifw, b_iff, b_idf, b_hold;
  logic [15:0] b_stall, b_flush;
  logic [1:0] b_state;
  logic [4:0] a_out, b_out;

  int tests = 0;
  int fails = 0;

  assign a_out = {a_pc, a_ifw, a_iff, a_idf, a_hold};
  assign b_out = {b_pc, b_ifw, b_iff, b_idf, b_hold};

  always #5 clk = ~clk;

  hazard_flush_ctrl #(.LU_STALL_CYCLES(1), .BRANCH_PENALTY(3), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .IDEX_MemRead(mem_read), .IDEX_RT(idex_rt),
    .IFID_RS(ifid_rs), .IFID_RT(ifid_rt), .IFID_uses_RT(uses_rt),
    .branch_taken(br), .mem_busy(busy),
    .PC_WRITE(a_pc), .IFID_WRITE(a_ifw), .IFID_FLUSH(a_iff), .IDEX_FLUSH(a_idf),
    .PIPE_HOLD(a_hold), .stall_cnt(a_stall), .flush_cnt(a_flush), .state_dbg(a_state)
  );

  hazard_flush_ctrl #(.LU_STALL_CYCLES(3), .BRANCH_PENALTY(1), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .IDEX_MemRead(mem_read), .IDEX_RT(idex_rt),
    .IFID_RS(ifid_rs), .IFID_RT(ifid_rt), .IFID_uses_RT(uses_rt),
    .branch_taken(br), .mem_busy(busy),
    .PC_WRITE(b_pc), .IFID_WRITE(b_ifw), .IFID_FLUSH(b_iff), .IDEX_FLUSH(b_idf),
    .PIPE_HOLD(b_hold), .stall_cnt(b_stall), .flush_cnt(b_flush), .state_dbg(b_state)
  );

  // Driver tasks: inputs change on the falling edge, checks run 1 ns later.
  task automatic set_idle();
    mem_read = 1'b0; idex_rt = 4'h0; ifid_rs = 4'h0; ifid_rt = 4'h0;
    uses_rt = 1'b0; br = 1'b0; busy = 1'b0;
  endtask

  task automatic set_lu();
    mem_read = 1'b1; idex_rt = 4'h3; ifid_rs = 4'h3; ifid_rt = 4'h0; uses_rt = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; set_idle();
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; set_idle(); #1;
    tests++; if (a_out !== RST_O) begin fails++; $display("FAIL reset_out_a: got %b want %b", a_out, RST_O); end
    tests++; if (b_out !== RST_O) begin fails++; $display("FAIL reset_out_b: got %b want %b", b_out, RST_O); end
    @(negedge clk); busy = 1'b1; br = 1'b1; set_lu(); #1;
    tests++; if (a_out !== RST_O) begin fails++; $display("FAIL reset_overrides_inputs: got %b want %b", a_out, RST_O); end
    @(negedge clk); rst = 1'b0; set_idle(); #1;
    tests++; if (a_state !== S_RUN) begin fails++; $display("FAIL reset_state: got %0d want %0d", a_state, S_RUN); end
    tests++; if (a_stall !== 4'd0) begin fails++; $display("FAIL reset_stall_cnt: got %0d want 0", a_stall); end
    tests++; if (a_flush !== 4'd0) begin fails++; $display("FAIL reset_flush_cnt: got %0d want 0", a_flush); end
    tests++; if (b_stall !== 16'd0) begin fails++; $display("FAIL reset_stall_cnt_b: got %0d want 0", b_stall); end
    tests++; if (a_out !== RUN_O) begin fails++; $display("FAIL post_reset_out: got %b want %b", a_out, RUN_O); end
  endtask

  task automatic test_load_use();
    do_reset();
    @(negedge clk); set_lu(); #1;
    tests++; if (a_out !== STALL_O) begin fails++; $display("FAIL lu_rs_stall: got %b want %b", a_out, STALL_O); end
    @(negedge clk); set_idle(); #1;
    tests++; if (a_out !== RUN_O) begin fails++; $display("FAIL lu_one_bubble: got %b want %b", a_out, RUN_O); end
    tests++; if (a_stall !== 4'd1) begin fails++; $display("FAIL lu_stall_cnt: got %0d want 1", a_stall); end
    tests++; if (a_state !== S_RUN) begin fails++; $display("FAIL lu_state: got %0d want %0d", a_state, S_RUN); end
  endtask

  task automatic test_uses_rt();
    do_reset();
    @(negedge clk); mem_read = 1'b1; idex_rt = 4'h3; ifid_rs = 4'h5; ifid_rt = 4'h3; uses_rt = 1'b0; #1;
    tests++; if (a_out !== RUN_O) begin fails++; $display("FAIL rt_unused_no_stall: got %b want %b", a_out, RUN_O); end
    @(negedge clk); uses_rt = 1'b1; #1;
    tests++; if (a_out !== STALL_O) begin fails++; $display("FAIL rt_used_stall: got %b want %b", a_out, STALL_O); end
    tests++; if (a_stall !== 4'd0) begin fails++; $display("FAIL rt_unused_cnt: got %0d want 0", a_stall); end
    @(negedge clk); idex_rt = 4'h0; ifid_rs = 4'h0; ifid_rt = 4'h7; uses_rt = 1'b0; #1;
    tests++; if (a_out !== STALL_O) begin fails++; $display("FAIL r0_stall: got %b want %b", a_out, STALL_O); end
    @(negedge clk); mem_read = 1'b0; #1;
    tests++; if (a_out !== RUN_O) begin fails++; $display("FAIL no_memread_no_stall: got %b want %b", a_out, RUN_O); end
    tests++; if (a_stall !== 4'd2) begin fails++; $display("FAIL rt_stall_cnt: got %0d want 2", a_stall); end
  endtask

  task automatic test_branch();
    do_reset();
    @(negedge clk); br = 1'b1; #1;
    tests++; if (a_out !== BR_O) begin fails++; $display("FAIL br_first: got %b want %b", a_out, BR_O); end
    tests++; if (b_out !== BR_O) begin fails++; $display("FAIL br_first_b: got %b want %b", b_out, BR_O); end
    @(negedge clk); set_idle(); #1;
    tests++; if (a_out !== BRF_O) begin fails++; $display("FAIL br_second: got %b want %b", a_out, BRF_O); end
    tests++; if (a_state !== S_BR) begin fails++; $display("FAIL br_state: got %0d want %0d", a_state, S_BR); end
    tests++; if (b_out !== RUN_O) begin fails++; $display("FAIL br_penalty1_b: got %b want %b", b_out, RUN_O); end
    @(negedge clk); #1;
    tests++; if (a_out !== BRF_O) begin fails++; $display("FAIL br_third: got %b want %b", a_out, BRF_O); end
    @(negedge clk); #1;
    tests++; if (a_out !== RUN_O) begin fails++; $display("FAIL br_done: got %b want %b", a_out, RUN_O); end
    tests++; if (a_flush !== 4'd1) begin fails++; $display("FAIL br_flush_cnt: got %0d want 1", a_flush); end
    tests++; if (b_flush !== 16'd1) begin fails++; $display("FAIL br_flush_cnt_b: got %0d want 1", b_flush); end
    // Second branch while still flushing restarts the penalty window.
    do_reset();
    @(negedge clk); br = 1'b1;
    @(negedge clk); br = 1'b0;
    @(negedge clk); br = 1'b1; #1;
    tests++; if (a_out !== BR_O) begin fails++; $display("FAIL br_reload_out: got %b want %b", a_out, BR_O); end
    @(negedge clk); br = 1'b0; #1;
    tests++; if (a_out !== BRF_O) begin fails++; $display("FAIL br_reload_1: got %b want %b", a_out, BRF_O); end
    @(negedge clk); #1;
    tests++; if (a_out !== BRF_O) begin fails++; $display("FAIL br_reload_2: got %b want %b", a_out, BRF_O); end
    @(negedge clk); #1;
    tests++; if (a_out !== RUN_O) begin fails++; $display("FAIL br_reload_done: got %b want %b", a_out, RUN_O); end
    tests++; if (a_flush !== 4'd2) begin fails++; $display("FAIL br_reload_cnt: got %0d want 2", a_flush); end
  endtask

  task automatic test_mem_busy();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); busy = 1'b1; br = 1'b1; set_lu(); #1;
      tests++; if (a_out !== HOLD_O) begin fails++; $display("FAIL busy_hold_%0d: got %b want %b", i, a_out, HOLD_O); end
    end
    @(negedge clk); busy = 1'b0; #1;
    tests++; if (a_out !== BR_O) begin fails++; $display("FAIL busy_then_branch: got %b want %b", a_out, BR_O); end
    @(negedge clk); set_idle(); #1;
    tests++; if (a_out !== BRF_O) begin fails++; $display("FAIL busy_br_flush: got %b want %b", a_out, BRF_O); end
    tests++; if (a_stall !== 4'd4) begin fails++; $display("FAIL busy_stall_cnt: got %0d want 4", a_stall); end
    tests++; if (a_flush !== 4'd1) begin fails++; $display("FAIL busy_flush_cnt: got %0d want 1", a_flush); end
    @(negedge clk); busy = 1'b1; #1;
    tests++; if (a_out !== HOLD_O) begin fails++; $display("FAIL busy_in_brflush: got %b want %b", a_out, HOLD_O); end
    @(negedge clk); busy = 1'b0; #1;
    tests++; if (a_out !== BRF_O) begin fails++; $display("FAIL busy_cnt_held: got %b want %b", a_out, BRF_O); end
    @(negedge clk); #1;
    tests++; if (a_out !== RUN_O) begin fails++; $display("FAIL busy_brflush_done: got %b want %b", a_out, RUN_O); end
    tests++; if (a_stall !== 4'd5) begin fails++; $display("FAIL busy_stall_cnt2: got %0d want 5", a_stall); end
  endtask

  task automatic test_lu_stall();
    do_reset();
    @(negedge clk); set_lu(); #1;
    tests++; if (b_out !== STALL_O) begin fails++; $display("FAIL lus_first: got %b want %b", b_out, STALL_O); end
    @(negedge clk); set_idle(); #1;
    tests++; if (b_out !== STALL_O) begin fails++; $display("FAIL lus_second: got %b want %b", b_out, STALL_O); end
    tests++; if (b_state !== S_LU) begin fails++; $display("FAIL lus_state: got %0d want %0d", b_state, S_LU); end
    @(negedge clk); #1;
    tests++; if (b_out !== STALL_O) begin fails++; $display("FAIL lus_third: got %b want %b", b_out, STALL_O); end
    @(negedge clk); #1;
    tests++; if (b_out !== RUN_O) begin fails++; $display("FAIL lus_done: got %b want %b", b_out, RUN_O); end
    tests++; if (b_stall !== 16'd3) begin fails++; $display("FAIL lus_stall_cnt: got %0d want 3", b_stall); end
    @(negedge clk); set_lu();
    @(negedge clk); set_idle(); br = 1'b1; #1;
    tests++; if (b_out !== BR_O) begin fails++; $display("FAIL lus_abort_branch: got %b want %b", b_out, BR_O); end
    @(negedge clk); set_idle(); #1;
    tests++; if (b_out !== RUN_O) begin fails++; $display("FAIL lus_abort_run: got %b want %b", b_out, RUN_O); end
    tests++; if (b_stall !== 16'd4) begin fails++; $display("FAIL lus_abort_stall: got %0d want 4", b_stall); end
    tests++; if (b_flush !== 16'd1) begin fails++; $display("FAIL lus_abort_flush: got %0d want 1", b_flush); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); set_lu();
      @(negedge clk); set_idle();
    end
    #1;
    tests++; if (a_stall !== 4'd15) begin fails++; $display("FAIL stall_saturate: got %0d want 15", a_stall); end
    for (int i = 0; i < 17; i++) begin
      @(negedge clk); br = 1'b1;
    end
    @(negedge clk); set_idle(); #1;
    tests++; if (a_flush !== 4'd15) begin fails++; $display("FAIL flush_saturate: got %0d want 15", a_flush); end
    do_reset();
    @(negedge clk); set_lu();
    @(negedge clk); set_idle(); #1;
    tests++; if (b_state !== S_LU) begin fails++; $display("FAIL rst_mid_pre: got %0d want %0d", b_state, S_LU); end
    @(negedge clk); rst = 1'b1; #1;
    tests++; if (b_out !== RST_O) begin fails++; $display("FAIL rst_mid_out: got %b want %b", b_out, RST_O); end
    @(negedge clk); rst = 1'b0; #1;
    tests++; if (b_state !== S_RUN) begin fails++; $display("FAIL rst_mid_state: got %0d want %0d", b_state, S_RUN); end
    tests++; if (b_out !== RUN_O) begin fails++; $display("FAIL rst_mid_run: got %b want %b", b_out, RUN_O); end
    tests++; if (b_stall !== 16'd0) begin fails++; $display("FAIL rst_mid_cnt: got %0d want 0", b_stall); end
  endtask

  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog: got timeout want finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_idle();
    test_reset();
    test_load_use();
    test_uses_rt();
    test_branch();
    test_mem_busy();
    test_lu_stall();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
